// File: rtl/gift_pkg.sv
// rtl/gift_pkg.sv - GIFT cipher constants, index/round helpers and FSM state type
package gift_pkg;

    typedef enum logic {IDLE, RUN} fsm_t;

    // Nibble x of this vector is S(x), so SBOX[4*x +: 4] is the substitution.
    localparam logic [63:0] SBOX = 64'he805_7bd2_93f6_c4a1;

    function automatic int perm_idx(input int i, input int width);
        return 4 * (i / 16) + (width / 4) * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

    function automatic int rounds_of(input int width);
        return (width == 64) ? 28 : 40;
    endfunction

    function automatic logic [5:0] rc_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

    // k7..k0 <= (k1 >>> 2) || (k0 >>> 12) || k7..k2
    function automatic logic [127:0] key_next(input logic [127:0] k);
        return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
    endfunction

endpackage

// File: rtl/gift_round.sv
// rtl/gift_round.sv - one combinational GIFT round: SubCells, PermBits, AddRoundKey/constant
module gift_round
    import gift_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] state,
    input  logic [127:0]     kreg,
    input  logic [5:0]       rc,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] sub;
    logic [WIDTH-1:0] perm;
    logic [WIDTH-1:0] rk;
    logic [WIDTH-1:0] cm;
    logic             unused_kreg;

    assign unused_kreg = ^kreg;

    for (genvar n = 0; n < WIDTH / 4; n++) begin : g_sub
        assign sub[4*n +: 4] = SBOX[{state[4*n +: 4], 2'b00} +: 4];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_perm
        assign perm[perm_idx(i, WIDTH)] = sub[i];
    end

    if (WIDTH == 64) begin : g_rk64
        for (genvar i = 0; i < 16; i++) begin : g_b
            assign rk[4*i +: 4] = {2'b00, kreg[16+i], kreg[i]};
        end
    end else begin : g_rk128
        // U = k5||k4 lands on bit 4i+2, V = k1||k0 on bit 4i+1.
        for (genvar i = 0; i < 32; i++) begin : g_b
            assign rk[4*i +: 4] = {1'b0, kreg[64+i], kreg[i], 1'b0};
        end
    end

    always_comb begin
        cm            = '0;
        cm[WIDTH-1]   = 1'b1;
        cm[23]        = rc[5];
        cm[19]        = rc[4];
        cm[15]        = rc[3];
        cm[11]        = rc[2];
        cm[7]         = rc[1];
        cm[3]         = rc[0];
    end

    assign next = perm ^ rk ^ cm;

endmodule

// File: rtl/gift_iter_core.sv
// rtl/gift_iter_core.sv - iterative GIFT-64/128 encryption core; GIFT_UNROLL2_EN runs two rounds per cycle
module gift_iter_core
    import gift_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pt,
    input  logic [127:0]     key,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ct
);

    localparam int ROUNDS = rounds_of(WIDTH);
    localparam int CW     = $clog2(ROUNDS);

    if (WIDTH != 64 && WIDTH != 128) begin : g_bad_width
        $error("gift_iter_core: WIDTH must be 64 or 128");
    end

    fsm_t             fsm;
    logic [WIDTH-1:0] state;
    logic [127:0]     kreg;
    logic [5:0]       rc;
    logic [CW-1:0]    cnt;

    logic [5:0]       rc1;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] nxt;
    logic [5:0]       rc_adv;
    logic [127:0]     k_adv;

    assign rc1 = rc_next(rc);

    gift_round #(.WIDTH(WIDTH)) u_round0 (
        .state (state),
        .kreg  (kreg),
        .rc    (rc1),
        .next  (r1)
    );

`ifdef GIFT_UNROLL2_EN
    localparam int STEPS = ROUNDS / 2;

    logic [127:0]     k1;
    logic [5:0]       rc2;
    logic [WIDTH-1:0] r2;

    assign k1  = key_next(kreg);
    assign rc2 = rc_next(rc1);

    gift_round #(.WIDTH(WIDTH)) u_round1 (
        .state (r1),
        .kreg  (k1),
        .rc    (rc2),
        .next  (r2)
    );

    assign nxt    = r2;
    assign rc_adv = rc2;
    assign k_adv  = key_next(k1);
`else
    localparam int STEPS = ROUNDS;

    assign nxt    = r1;
    assign rc_adv = rc1;
    assign k_adv  = key_next(kreg);
`endif

    assign ready = (fsm == IDLE);
    assign busy  = (fsm == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm   <= IDLE;
            state <= '0;
            kreg  <= '0;
            rc    <= '0;
            cnt   <= '0;
            ct    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state <= pt;
                        kreg  <= key;
                        rc    <= 6'h00;
                        cnt   <= '0;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    state <= nxt;
                    kreg  <= k_adv;
                    rc    <= rc_adv;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) begin
                        ct   <= nxt;
                        done <= 1'b1;
                        fsm  <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gift_iter_core.sv
// tb/tb_gift_iter_core.sv - self-checking bench for gift_iter_core (GIFT-128 and GIFT-64 instances)
module tb_gift_iter_core;

`ifdef GIFT_UNROLL2_EN
    localparam int LAT128 = 20;
    localparam int LAT64  = 14;
`else
    localparam int LAT128 = 40;
    localparam int LAT64  = 28;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start, ready, busy, done;
    logic [127:0] pt, key, ct;
    logic         start64, ready64, busy64, done64;
    logic [63:0]  pt64, ct64;
    logic [127:0] key64;

    int ncmp = 0;
    int nfail = 0;

    gift_iter_core #(.WIDTH(128)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pt    (pt),
        .key   (key),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .ct    (ct)
    );

    gift_iter_core #(.WIDTH(64)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .start (start64),
        .pt    (pt64),
        .key   (key64),
        .ready (ready64),
        .busy  (busy64),
        .done  (done64),
        .ct    (ct64)
    );

    // Straight-from-the-cipher-definition model working on arrays of key words.
    function automatic logic [127:0] ref_enc(input logic [127:0] p, input logic [127:0] k, input int w);
        logic [127:0] s, t;
        logic [15:0]  kw [8];
        logic [15:0]  nk [8];
        int           rc, nr, pi;
        int           sbox [16] = '{1, 10, 4, 12, 6, 15, 3, 9, 2, 13, 11, 7, 5, 0, 8, 14};
        s  = p;
        for (int j = 0; j < 8; j++) kw[j] = k[16*j +: 16];
        nr = (w == 64) ? 28 : 40;
        rc = 0;
        for (int r = 0; r < nr; r++) begin
            for (int n = 0; n < w / 4; n++) s[4*n +: 4] = 4'(sbox[s[4*n +: 4]]);
            t = '0;
            for (int i = 0; i < w; i++) begin
                pi = 4 * (i / 16) + (w / 4) * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
                t[pi] = s[i];
            end
            if (w == 64) begin
                for (int i = 0; i < 16; i++) begin
                    t[4*i+1] ^= kw[1][i];
                    t[4*i]   ^= kw[0][i];
                end
            end else begin
                for (int i = 0; i < 32; i++) begin
                    t[4*i+2] ^= (i < 16) ? kw[4][i] : kw[5][i-16];
                    t[4*i+1] ^= (i < 16) ? kw[0][i] : kw[1][i-16];
                end
            end
            rc = ((rc << 1) & 63) | (((rc >> 5) ^ (rc >> 4) ^ 1) & 1);
            t[w-1] ^= 1'b1;
            for (int b = 0; b < 6; b++) t[3+4*b] ^= 1'((rc >> b) & 1);
            nk[7] = {kw[1][1:0], kw[1][15:2]};
            nk[6] = {kw[0][11:0], kw[0][15:12]};
            for (int j = 0; j < 6; j++) nk[j] = kw[j+2];
            kw = nk;
            s  = t;
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w64, input bit s, input logic [127:0] p, input logic [127:0] k);
        if (w64) begin
            start64 = s; pt64 = p[63:0]; key64 = k;
        end else begin
            start = s; pt = p; key = k;
        end
    endtask

    function automatic bit dn(input bit w64);
        return w64 ? done64 : done;
    endfunction

    function automatic bit rdy(input bit w64);
        return w64 ? ready64 : ready;
    endfunction

    function automatic logic [127:0] ctv(input bit w64);
        return w64 ? {64'b0, ct64} : ct;
    endfunction

    function automatic int lat(input bit w64);
        return w64 ? LAT64 : LAT128;
    endfunction

    function automatic int wd(input bit w64);
        return w64 ? 64 : 128;
    endfunction

    // Called #1 after a rising edge; returns cycles from the acceptance edge to done.
    task automatic run_op(input bit w64, input logic [127:0] p, input logic [127:0] k,
                          output int n, output logic [127:0] res);
        drive(w64, 1'b1, p, k);
        @(posedge clk); #1;
        drive(w64, 1'b0, p, k);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (dn(w64)) break;
        end
        res = ctv(w64);
    endtask

    task automatic op_check(input bit w64, input logic [127:0] p, input logic [127:0] k, input string tag);
        int n;
        logic [127:0] res;
        run_op(w64, p, k, n, res);
        check({tag, "_lat"}, 128'(n), 128'(lat(w64)));
        check({tag, "_ct"}, res, ref_enc(p, k, wd(w64)));
    endtask

    task automatic held_run(input bit w64, input string tag);
        logic [127:0] pa [3];
        logic [127:0] k;
        int idx, c, last;
        k = rnd128();
        for (int i = 0; i < 3; i++) pa[i] = rnd128();
        idx  = 0;
        last = 0;
        drive(w64, 1'b1, pa[0], k);
        for (c = 1; c <= 4 * (lat(w64) + 1) + 10 && idx < 3; c++) begin
            @(posedge clk); #1;
            if (dn(w64)) begin
                check({tag, "_ct"}, ctv(w64), ref_enc(pa[idx], k, wd(w64)));
                if (idx == 0) check({tag, "_first"}, 128'(c), 128'(lat(w64) + 1));
                else          check({tag, "_gap"}, 128'(c - last), 128'(lat(w64) + 1));
                last = c;
                idx++;
                if (idx < 3) drive(w64, 1'b1, pa[idx], k);
                else         drive(w64, 1'b0, pa[0], k);
            end
        end
        drive(w64, 1'b0, pa[0], k);
        check({tag, "_count"}, 128'(idx), 128'd3);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, ndone, donecyc, rdy_bad;
        logic [127:0] res, p1, k1, p2, k2;

        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 128'(ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_ct", ct, 128'd0);
        check("rst_ready64", 128'(ready64), 128'd1);
        check("rst_ct64", {64'b0, ct64}, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Published zero-key/zero-plaintext vectors.
        run_op(1'b1, '0, '0, n, res);
        check("kat64_lat", 128'(n), 128'(LAT64));
        check("kat64_ct", res, {64'b0, 64'hf62bc3ef34f775ac});
        run_op(1'b0, '0, '0, n, res);
        check("kat128_lat", 128'(n), 128'(LAT128));
        check("kat128_ct", res, 128'hcd0bd738388ad3f668b15a36ceb6ff92);

        for (int i = 0; i < 100; i++) op_check(1'b0, rnd128(), rnd128(), "rand128");
        for (int i = 0; i < 50; i++)  op_check(1'b1, rnd128(), rnd128(), "rand64");

        // A second start mid-run must be dropped.
        p1 = rnd128(); k1 = rnd128(); p2 = rnd128(); k2 = rnd128();
        drive(1'b0, 1'b1, p1, k1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, p1, k1);
        ndone = 0; donecyc = -1; rdy_bad = 0; res = '0;
        for (int c = 1; c <= LAT128 + 20; c++) begin
            if (c == 10) drive(1'b0, 1'b1, p2, k2);
            if (c == 11) drive(1'b0, 1'b0, p2, k2);
            @(posedge clk); #1;
            if (done) begin ndone++; donecyc = c; end
            if (c < LAT128 && rdy(1'b0)) rdy_bad++;
            if (c == LAT128) res = ct;
        end
        check("busy_start_ndone", 128'(ndone), 128'd1);
        check("busy_start_cycle", 128'(donecyc), 128'(LAT128));
        check("busy_start_ct", res, ref_enc(p1, k1, 128));
        check("busy_start_ready_low", 128'(rdy_bad), 128'd0);
        check("busy_start_ct_held", ct, ref_enc(p1, k1, 128));

        // Reset partway through a run aborts it.
        drive(1'b0, 1'b1, rnd128(), rnd128());
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (LAT128 / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ready", 128'(ready), 128'd1);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_ct", ct, 128'd0);
        check("abort_done", 128'(done), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < LAT128 + 10; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", 128'(ndone), 128'd0);
        op_check(1'b0, rnd128(), rnd128(), "after_abort");

        held_run(1'b0, "held128");
        held_run(1'b1, "held64");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
